// File: rtl/mux_reg_8x8.sv
// Page register bank: DEPTH x WIDTH registers with enable-per-register writes,
// AND-OR read mux and a serial scan chain. Define MUX_REG_8X8_OUTREG_EN to register out_data.
module mux_reg_8x8_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tc,
  input  logic             scan_in,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Scan takes priority so functional writes cannot corrupt a shift in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (tc) q <= {q[WIDTH-2:0], scan_in};
    else if (ld) q <= d;
  end
endmodule

module mux_reg_8x8 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [DEPTH-1:0] en_in,
  output logic [WIDTH-1:0] out_data,
  input  logic [DEPTH-1:0] en_out,
  input  logic             tc,
  input  logic             td,
  output logic             tq
);
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            scan_in;
  logic [WIDTH-1:0]            mux;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (i == 0) begin : g_head
      assign scan_in[i] = td;
    end else begin : g_link
      assign scan_in[i] = regs[i-1][WIDTH-1];
    end
    mux_reg_8x8_cell #(.WIDTH(WIDTH)) u_cell (
      .clk     (clk),
      .reset   (reset),
      .tc      (tc),
      .scan_in (scan_in[i]),
      .ld      (en_in[i]),
      .d       (in_data),
      .q       (regs[i])
    );
  end

  // No priority among selects: overlapping selects OR together.
  always_comb begin
    mux = '0;
    for (int i = 0; i < DEPTH; i++)
      mux = mux | (regs[i] & {WIDTH{en_out[i]}});
  end

`ifdef MUX_REG_8X8_OUTREG_EN
  logic [WIDTH-1:0] out_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_q <= '0;
    else       out_q <= mux;
  end
  assign out_data = out_q;
`else
  assign out_data = mux;
`endif

  assign tq = regs[DEPTH-1][WIDTH-1];
endmodule

// File: tb/tb_mux_reg_8x8.sv
// Bench for mux_reg_8x8: 64-bit chain model checked every cycle plus directed literals.
module tb_mux_reg_8x8;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0, en_in = '0, en_out = '0;
  logic       tc = 1'b0, td = 1'b0;
  logic [7:0] out_data;
  logic       tq;

  int checks = 0, errors = 0;
  bit run = 1'b0;

  mux_reg_8x8 dut (
    .clk(clk), .reset(reset), .in_data(in_data), .en_in(en_in),
    .out_data(out_data), .en_out(en_out), .tc(tc), .td(td), .tq(tq)
  );

  always #5 clk = ~clk;

  // Model: whole array as one 64-bit word, byte i = register i.
  logic [63:0] m;
  logic [7:0]  mq;

  function automatic logic [7:0] sel(input logic [63:0] a, input logic [7:0] e);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) if (e[i]) r = r | a[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin : mdl_upd
    logic [63:0] n;
    if (reset) begin
      m  <= '0;
      mq <= '0;
    end else begin
      n = m;
      if (tc) n = {m[62:0], td};
      else for (int i = 0; i < 8; i++) if (en_in[i]) n[8*i +: 8] = in_data;
      mq <= sel(m, en_out);
      m  <= n;
    end
  end

  function automatic logic [7:0] exp_out();
`ifdef MUX_REG_8X8_OUTREG_EN
    return mq;
`else
    return sel(m, en_out);
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (run) begin
    chk("model_out", out_data, exp_out());
    chk("model_tq", {7'b0, tq}, {7'b0, m[63]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] en, input logic [7:0] d);
    en_in = en; in_data = d;
    tick();
    en_in = '0;
  endtask

  // Two edges make the result valid in both read-latency builds.
  task automatic rd(input string name, input logic [7:0] sel_v, input logic [7:0] exp);
    en_out = sel_v;
    tick(); tick();
    chk(name, out_data, exp);
  endtask

  logic [63:0] pat;
  logic [7:0]  pat_b [8];

  initial begin
    pat = 64'h0123_4567_89AB_CDEF;
    pat_b = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run = 1'b1;
    chk("reset_out", out_data, 8'h00);
    chk("reset_tq", {7'b0, tq}, 8'h00);

    // single write/read, then a second register leaves the first intact
    en_out = 8'h01;
    wr(8'h01, 8'hA5);
    rd("rd_reg0", 8'h01, 8'hA5);
    wr(8'h80, 8'h3C);
    rd("rd_reg7", 8'h80, 8'h3C);
    rd("reg0_hold", 8'h01, 8'hA5);

    // OR of several selects, and empty select
    wr(8'h01, 8'hF0);
    wr(8'h02, 8'h0F);
    rd("or_sel", 8'h03, 8'hFF);
    rd("no_sel", 8'h00, 8'h00);

    // broadcast write
    wr(8'h7C, 8'h96);
    rd("bcast", 8'h7C, 8'h96);
    rd("bcast_or", 8'h7D, 8'hF6);

    // asynchronous reset mid-cycle
    wr(8'h80, 8'h81);
    rd("tq_pre", 8'h83, 8'hFF);
    chk("tq_set", {7'b0, tq}, 8'h01);
    #2 reset = 1'b1;
    #1;
    chk("async_out", out_data, 8'h00);
    chk("async_tq", {7'b0, tq}, 8'h00);
    @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) rd("post_reset", 8'(1 << i), 8'h00);

    // same-edge write and read
    en_out = 8'h08;
    wr(8'h08, 8'h5A);
`ifdef MUX_REG_8X8_OUTREG_EN
    chk("wr_rd_edge1", out_data, 8'h00);
    tick();
`endif
    chk("wr_rd_same", out_data, 8'h5A);

    // scan 64 cycles: single 1 lands in reg7 msb; en_in pulse ignored
    tc = 1'b1; td = 1'b1;
    tick();
    td = 1'b0;
    for (int k = 1; k < 64; k++) begin
      if (k == 30) begin en_in = 8'hFF; in_data = 8'hFF; end
      tick();
      en_in = '0;
    end
    chk("scan_tq", {7'b0, tq}, 8'h01);
    tc = 1'b0;
    rd("scan_reg7", 8'h80, 8'h80);
    rd("scan_rest", 8'h7F, 8'h00);

    // scan-load pattern msb first, then read each byte
    tc = 1'b1;
    for (int k = 63; k >= 0; k--) begin
      td = pat[k];
      tick();
    end
    tc = 1'b0; td = 1'b0;
    for (int i = 0; i < 8; i++) rd("scan_load", 8'(1 << i), pat_b[i]);

    // shift part way, pause, resume: chain continues where it left off
    tc = 1'b1;
    repeat (4) tick();
    tc = 1'b0;
    tick();
    tc = 1'b1;
    repeat (4) tick();
    tc = 1'b0;
    rd("resume_reg0", 8'h01, 8'h00);
    rd("resume_reg1", 8'h02, 8'hEF);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
